down_counter_timer: RTL

Loadable down-counting timer: counts a loaded value down to zero at a programmable prescaled rate, then reports completion with a one-cycle `done` pulse. It is the counterpart to the team's free-running up counter. It is used wherever a block must wait a bounded number of ticks, such as timeouts, delays and LED/PWM holds. Run/pause is controlled with `enable`, and a new value can be loaded at any time.

---
 rtl/down_counter_timer_pkg.sv | 13 +
 rtl/down_counter_timer_tick.sv | 49 ++++
 rtl/down_counter_timer.sv | 116 +++++++++++
 3 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared types and default constants for the loadable down-counting timer.
package down_counter_timer_pkg;

  localparam int DCT_WIDTH    = 8;
  localparam int DCT_PRESCALE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } dct_state_t;

endpackage

// File: rtl/down_counter_timer_tick.sv
// tick_prescaler: divides enabled cycles by PRESCALE and pulses tick on the last phase.
module tick_prescaler
  import down_counter_timer_pkg::*;
#(
  parameter int PRESCALE = DCT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last_s;

  // Phase counter next state; holds when not running so a pause keeps the phase.
  always_comb begin
    at_last_s = (cnt_q == LAST);
    cnt_d     = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (run) begin
      if (at_last_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run & at_last_s;

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with prescaled decrement and one-cycle done pulse.
// Optional periodic mode: define DOWN_COUNTER_TIMER_AUTORELOAD_EN.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH    = DCT_WIDTH,
  parameter int PRESCALE = DCT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  dct_state_t       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             run_s;
  logic             tick_s;

  // PAUSE with enable high counts in that same cycle, so a pause costs exactly its length.
  assign run_s = ~load & enable & (state_q != IDLE);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(load),
    .run  (run_s),
    .tick (tick_s)
  );

  // FSM, count, reload and done next-state logic; load overrides everything.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      out_d    = load_value;
      reload_d = load_value;
      if (load_value == ZERO) begin
        state_d = IDLE;
      end else if (enable) begin
        state_d = RUN;
      end else begin
        state_d = PAUSE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN, PAUSE: begin
          if (!enable) begin
            state_d = PAUSE;
          end else if (tick_s) begin
            if (out_q > ONE) begin
              out_d   = out_q - ONE;
              state_d = RUN;
            end else if (out_q == ONE) begin
              done_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
              out_d   = reload_q;
              state_d = RUN;
`else
              out_d   = ZERO;
              state_d = IDLE;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      out_q    <= ZERO;
      reload_q <= ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
